mem_ctrl: RTL and testbench

Single-port memory controller/arbiter between the CPU pipeline and the byte-wide RAM. It serialises 32-bit instruction fetches from the IF stage and load/store requests from the MEM stage into byte accesses on the one RAM port, then reassembles and extends read data. It drives `mem_busy` back to the MEM stage, which only issues a request when `mem_busy` is 0.

---
 rtl/mem_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Single-port byte-wide RAM controller: arbitrates IF fetches against MEM loads/stores,
// serialises each word into byte accesses and reassembles/extends the read data.
module mem_ctrl #(
  parameter int RAM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_busy,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        mem_req,
  input  logic [31:0] mem_req_addr,
  input  logic [31:0] mem_req_data,
  input  logic [3:0]  mem_req_type,
  output logic        mem_busy,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_addr,
  output logic        ram_wr
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  localparam logic [3:0] T_LB  = 4'd1;
  localparam logic [3:0] T_LH  = 4'd2;
  localparam logic [3:0] T_LW  = 4'd3;
  localparam logic [3:0] T_LHU = 4'd4;
  localparam logic [3:0] T_LBU = 4'd5;
  localparam logic [3:0] T_SB  = 4'd6;
  localparam logic [3:0] T_SH  = 4'd7;
  localparam logic [3:0] T_SW  = 4'd8;
  localparam logic [2:0] LAT   = 3'(RAM_LATENCY);

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [2:0]  nbytes_q;
  logic [31:0] base_q;
  logic [31:0] wdata_q;
  logic [31:0] rbuf_q;
  logic [3:0]  type_q;
  logic        grant_if_q;
  logic [31:0] ram_addr_q;
  logic [7:0]  ram_dout_q;
  logic        ram_wr_q;
  logic        if_done_q;
  logic        mem_done_q;
  logic [31:0] if_data_q;
  logic [31:0] mem_rdata_q;

  logic        mem_valid;
  logic        req_store;
  logic [2:0]  req_size;
  logic [2:0]  cnt_inc;
  logic [2:0]  rd_last;
  logic [31:0] word_asm;
  logic [31:0] load_ext;
  logic [7:0]  wbyte [4];

  assign mem_valid = mem_req && (mem_req_type >= T_LB) && (mem_req_type <= T_SW);
  assign req_store = (mem_req_type >= T_SB);
  assign cnt_inc   = cnt_q + 3'd1;
  // Last READ cycle is the one that captures the final byte, LAT cycles after its address.
  assign rd_last   = nbytes_q + (LAT - 3'd1);

  always_comb begin
    case (mem_req_type)
      T_LB, T_LBU, T_SB: req_size = 3'd1;
      T_LH, T_LHU, T_SH: req_size = 3'd2;
      default:           req_size = 3'd4;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_asm[8*gi +: 8] = (cnt_q == 3'(gi) + LAT) ? ram_din : rbuf_q[8*gi +: 8];
    assign wbyte[gi]           = wdata_q[8*gi +: 8];
  end

  always_comb begin
    case (type_q)
      T_LB:    load_ext = {{24{word_asm[7]}}, word_asm[7:0]};
      T_LH:    load_ext = {{16{word_asm[15]}}, word_asm[15:0]};
      T_LBU:   load_ext = {24'd0, word_asm[7:0]};
      T_LHU:   load_ext = {16'd0, word_asm[15:0]};
      default: load_ext = word_asm;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      nbytes_q    <= 3'd0;
      base_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rbuf_q      <= 32'd0;
      type_q      <= 4'd0;
      grant_if_q  <= 1'b0;
      ram_addr_q  <= 32'd0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q  <= 3'd0;
          rbuf_q <= 32'd0;
          if (mem_valid) begin
            grant_if_q <= 1'b0;
            base_q     <= mem_req_addr;
            wdata_q    <= mem_req_data;
            type_q     <= mem_req_type;
            nbytes_q   <= req_size;
            ram_addr_q <= mem_req_addr;
            if (req_store) begin
              state_q    <= S_WRITE;
              ram_wr_q   <= 1'b1;
              ram_dout_q <= mem_req_data[7:0];
            end else begin
              state_q <= S_READ;
            end
          end else if (if_req) begin
            grant_if_q <= 1'b1;
            base_q     <= if_addr;
            type_q     <= T_LW;
            nbytes_q   <= 3'd4;
            ram_addr_q <= if_addr;
            state_q    <= S_READ;
          end
        end
        S_READ: begin
          rbuf_q <= word_asm;
          cnt_q  <= cnt_inc;
          if (cnt_q == rd_last) begin
            state_q <= S_DONE;
            if (grant_if_q) begin
              if_data_q <= word_asm;
              if_done_q <= 1'b1;
            end else begin
              mem_rdata_q <= load_ext;
              mem_done_q  <= 1'b1;
            end
          end else if (cnt_inc < nbytes_q) begin
            ram_addr_q <= base_q + {29'd0, cnt_inc};
          end
        end
        S_WRITE: begin
          if (cnt_q == nbytes_q - 3'd1) begin
            state_q    <= S_DONE;
            ram_wr_q   <= 1'b0;
            ram_dout_q <= 8'd0;
            mem_done_q <= 1'b1;
          end else begin
            cnt_q      <= cnt_inc;
            ram_addr_q <= base_q + {29'd0, cnt_inc};
            ram_dout_q <= wbyte[cnt_inc[1:0]];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Busy flags are combinational so the MEM stage sees a same-cycle IF grant.
  assign if_busy   = rst & if_req & ~if_done_q;
  assign mem_busy  = rst & ((state_q != S_IDLE) | (if_req & ~mem_valid));
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed-vector bench for mem_ctrl with a 1-cycle-latency byte RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_busy;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_type;
  logic        mem_busy;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_addr;
  logic        ram_wr;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] ram [0:1023];
  logic       pl_we;
  logic [9:0] pl_addr;
  logic [7:0] pl_data;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (ram_wr) ram[ram_addr[9:0]] <= ram_dout;
    ram_din <= ram[ram_addr[9:0]];
  end

  mem_ctrl #(.RAM_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_busy(if_busy), .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_type(mem_req_type), .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_wr(ram_wr)
  );

  task automatic poke(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0;
    mem_req_addr = '0; mem_req_data = '0; mem_req_type = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 1024; i++) poke(10'(i), 8'h00);
    poke(10'h100, 8'h13); poke(10'h101, 8'h05); poke(10'h102, 8'h10); poke(10'h103, 8'h00);
    poke(10'h020, 8'h80); poke(10'h021, 8'h11); poke(10'h022, 8'h22); poke(10'h023, 8'h33);
    poke(10'h042, 8'h5A);
    @(negedge clk);
    pl_we = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({ram_wr, if_done, mem_done, if_busy, mem_busy} !== 5'b0) begin
      err_cnt++; $display("FAIL reset_flags got %b want 00000", {ram_wr, if_done, mem_done, if_busy, mem_busy});
    end
    vec_cnt++;
    if (ram_addr !== 32'h0 || ram_dout !== 8'h0) begin
      err_cnt++; $display("FAIL reset_ram got addr %h dout %h want 0/0", ram_addr, ram_dout);
    end
    vec_cnt++;
    if (if_data !== 32'h0 || mem_rdata !== 32'h0) begin
      err_cnt++; $display("FAIL reset_data got %h/%h want 0/0", if_data, mem_rdata);
    end
    rst = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (mem_busy !== 1'b0) begin
      err_cnt++; $display("FAIL idle_busy got %b want 0", mem_busy);
    end
    $display("reset: outputs cleared");
  endtask

  task automatic test_fetch();
    @(negedge clk);
    if_addr = 32'h100; if_req = 1'b1;
    #1;
    vec_cnt++;
    if (mem_busy !== 1'b1) begin
      err_cnt++; $display("FAIL fetch_accept_busy got %b want 1", mem_busy);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        vec_cnt++;
        if (ram_addr !== 32'h100 + 32'(k - 1) || ram_wr !== 1'b0) begin
          err_cnt++; $display("FAIL fetch_addr k=%0d got %h wr %b want %h wr 0", k, ram_addr, ram_wr, 32'h100 + 32'(k - 1));
        end
      end
      vec_cnt++;
      if (if_done !== (k == 6)) begin
        err_cnt++; $display("FAIL fetch_done k=%0d got %b want %b", k, if_done, (k == 6));
      end
      vec_cnt++;
      if (if_busy !== (k < 6)) begin
        err_cnt++; $display("FAIL fetch_if_busy k=%0d got %b want %b", k, if_busy, (k < 6));
      end
      if (k == 6) begin
        vec_cnt++;
        if (if_data !== 32'h00100513) begin
          err_cnt++; $display("FAIL fetch_data got %h want 00100513", if_data);
        end
        if_req = 1'b0;
      end
    end
    $display("fetch @100 -> %h", if_data);
  endtask

  task automatic test_lb_lbu();
    logic [3:0]  typ;
    logic [31:0] exp;
    for (int j = 0; j < 2; j++) begin
      typ = (j == 0) ? 4'd1 : 4'd5;
      exp = (j == 0) ? 32'hFFFFFF80 : 32'h00000080;
      @(negedge clk);
      mem_req_type = typ; mem_req_addr = 32'h20; mem_req = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (k == 1) begin
          vec_cnt++;
          if (ram_addr !== 32'h20 || ram_wr !== 1'b0) begin
            err_cnt++; $display("FAIL byte_load_addr type=%0d got %h wr %b want 20 wr 0", typ, ram_addr, ram_wr);
          end
        end
        vec_cnt++;
        if (mem_done !== (k == 3)) begin
          err_cnt++; $display("FAIL byte_load_done type=%0d k=%0d got %b want %b", typ, k, mem_done, (k == 3));
        end
        if (k == 3) begin
          vec_cnt++;
          if (mem_rdata !== exp) begin
            err_cnt++; $display("FAIL byte_load_data type=%0d got %h want %h", typ, mem_rdata, exp);
          end
          mem_req = 1'b0;
        end
      end
      $display("load type %0d @20 -> %h", typ, mem_rdata);
    end
  endtask

  task automatic test_sh();
    @(negedge clk);
    mem_req_type = 4'd7; mem_req_addr = 32'h40; mem_req_data = 32'hABCD1234; mem_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k <= 2) begin
        vec_cnt++;
        if (ram_wr !== 1'b1 || ram_addr !== 32'h40 + 32'(k - 1) || ram_dout !== ((k == 1) ? 8'h34 : 8'h12)) begin
          err_cnt++; $display("FAIL sh_write k=%0d got wr %b addr %h dout %h want wr 1 addr %h dout %h",
                              k, ram_wr, ram_addr, ram_dout, 32'h40 + 32'(k - 1), (k == 1) ? 8'h34 : 8'h12);
        end
      end
      if (k == 3) begin
        vec_cnt++;
        if (ram_wr !== 1'b0 || ram_dout !== 8'h00) begin
          err_cnt++; $display("FAIL sh_wr_off got wr %b dout %h want 0/00", ram_wr, ram_dout);
        end
      end
      vec_cnt++;
      if (mem_done !== (k == 3)) begin
        err_cnt++; $display("FAIL sh_done k=%0d got %b want %b", k, mem_done, (k == 3));
      end
      if (k == 3) mem_req = 1'b0;
    end
    vec_cnt++;
    if (ram[10'h040] !== 8'h34 || ram[10'h041] !== 8'h12 || ram[10'h042] !== 8'h5A) begin
      err_cnt++; $display("FAIL sh_ram got %h %h %h want 34 12 5a", ram[10'h040], ram[10'h041], ram[10'h042]);
    end
    $display("store SH ABCD1234 @40");
  endtask

  task automatic test_arbitration();
    @(negedge clk);
    if_addr = 32'h100; if_req = 1'b1;
    mem_req_type = 4'd3; mem_req_addr = 32'h20; mem_req = 1'b1;
    #1;
    vec_cnt++;
    if (mem_busy !== 1'b0) begin
      err_cnt++; $display("FAIL arb_mem_busy got %b want 0", mem_busy);
    end
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) begin
        vec_cnt++;
        if (ram_addr !== 32'h20) begin
          err_cnt++; $display("FAIL arb_first_addr got %h want 00000020", ram_addr);
        end
      end
      vec_cnt++;
      if (mem_done !== (k == 6)) begin
        err_cnt++; $display("FAIL arb_mem_done k=%0d got %b want %b", k, mem_done, (k == 6));
      end
      vec_cnt++;
      if (if_done !== (k == 13)) begin
        err_cnt++; $display("FAIL arb_if_done k=%0d got %b want %b", k, if_done, (k == 13));
      end
      if (k == 6) begin
        vec_cnt++;
        if (mem_rdata !== 32'h33221180) begin
          err_cnt++; $display("FAIL arb_lw_data got %h want 33221180", mem_rdata);
        end
      end
      if (k == 7) begin
        vec_cnt++;
        if (ram_addr !== 32'h23 || mem_busy !== 1'b0) begin
          err_cnt++; $display("FAIL arb_no_dup got addr %h busy %b want 23/0", ram_addr, mem_busy);
        end
        mem_req = 1'b0;
        #1;
        vec_cnt++;
        if (mem_busy !== 1'b1) begin
          err_cnt++; $display("FAIL arb_if_grant_busy got %b want 1", mem_busy);
        end
      end
      if (k == 8) begin
        vec_cnt++;
        if (ram_addr !== 32'h100) begin
          err_cnt++; $display("FAIL arb_fetch_addr got %h want 00000100", ram_addr);
        end
      end
      if (k == 13) begin
        vec_cnt++;
        if (if_data !== 32'h00100513) begin
          err_cnt++; $display("FAIL arb_fetch_data got %h want 00100513", if_data);
        end
        if_req = 1'b0;
      end
    end
    $display("arbitration: LW -> %h then fetch -> %h", mem_rdata, if_data);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    mem_req_type = 4'd8; mem_req_addr = 32'h80; mem_req_data = 32'hDEADBEEF; mem_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) begin
        vec_cnt++;
        if (ram_addr !== 32'h83 || ram_dout !== 8'hDE || ram_wr !== 1'b1) begin
          err_cnt++; $display("FAIL sw_last_byte got addr %h dout %h wr %b want 83/de/1", ram_addr, ram_dout, ram_wr);
        end
      end
      vec_cnt++;
      if (mem_done !== (k == 5)) begin
        err_cnt++; $display("FAIL sw_done k=%0d got %b want %b", k, mem_done, (k == 5));
      end
      if (k == 5) mem_req = 1'b0;
    end
    $display("store SW DEADBEEF @80");
    @(negedge clk);
    mem_req_type = 4'd3; mem_req_addr = 32'h80; mem_req = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      vec_cnt++;
      if (mem_done !== (k == 6)) begin
        err_cnt++; $display("FAIL b2b_lw_done k=%0d got %b want %b", k, mem_done, (k == 6));
      end
      if (k == 6) begin
        vec_cnt++;
        if (mem_rdata !== 32'hDEADBEEF) begin
          err_cnt++; $display("FAIL b2b_lw_data got %h want deadbeef", mem_rdata);
        end
        mem_req = 1'b0;
      end
    end
    $display("load LW @80 -> %h", mem_rdata);
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    mem_req_type = 4'd8; mem_req_addr = 32'h90; mem_req_data = 32'h11223344; mem_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k <= 2) begin
        vec_cnt++;
        if (ram_wr !== 1'b1 || ram_addr !== 32'h90 + 32'(k - 1)) begin
          err_cnt++; $display("FAIL abort_write k=%0d got wr %b addr %h want 1/%h", k, ram_wr, ram_addr, 32'h90 + 32'(k - 1));
        end
      end
      if (k == 2) begin
        rst = 1'b0; mem_req = 1'b0;
      end
      if (k == 3) begin
        vec_cnt++;
        if (ram_wr !== 1'b0 || ram_addr !== 32'h0 || mem_done !== 1'b0 || mem_busy !== 1'b0) begin
          err_cnt++; $display("FAIL abort_reset got wr %b addr %h done %b busy %b want 0/0/0/0", ram_wr, ram_addr, mem_done, mem_busy);
        end
        rst = 1'b1;
      end
      if (k == 4) begin
        vec_cnt++;
        if (mem_done !== 1'b0 || ram_wr !== 1'b0 || mem_busy !== 1'b0 || ram[10'h092] !== 8'h00) begin
          err_cnt++; $display("FAIL abort_idle got done %b wr %b busy %b ram92 %h want 0/0/0/00", mem_done, ram_wr, mem_busy, ram[10'h092]);
        end
      end
    end
    $display("store SW @90 aborted by reset");
    @(negedge clk);
    mem_req_type = 4'd1; mem_req_addr = 32'h90; mem_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      vec_cnt++;
      if (mem_done !== (k == 3)) begin
        err_cnt++; $display("FAIL post_reset_done k=%0d got %b want %b", k, mem_done, (k == 3));
      end
      if (k == 3) begin
        vec_cnt++;
        if (mem_rdata !== 32'h00000044) begin
          err_cnt++; $display("FAIL post_reset_data got %h want 00000044", mem_rdata);
        end
        mem_req = 1'b0;
      end
    end
    $display("load LB @90 -> %h", mem_rdata);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_lb_lbu();
    test_sh();
    test_arbitration();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
